// File: rtl/hwpe_ctrl_reqrsp_arbiter_pkg.sv
// Shared types and constants for the reqrsp arbiter and the benches that
// talk to the HWPE control target through it.
package hwpe_ctrl_package;

    // Arbiter is either free to pick a new initiator or holding one whose
    // request the target has not yet accepted.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } reqrsp_arb_state_t;

    // Register indices of the reqrsp configuration target.
    localparam int unsigned TRIGGER = 0;
    localparam int unsigned STATUS  = 1;
    localparam int unsigned JOBID   = 2;
    localparam int unsigned ACQUIRE = 3;
    localparam int unsigned PUSH    = 4;
    localparam int unsigned PULL    = 5;

    // Registers are 64 bits wide, so consecutive indices are 8 bytes apart.
    function automatic logic [31:0] reg_addr(input int unsigned idx);
        return 32'(idx << 3);
    endfunction

endpackage

// File: rtl/hwpe_ctrl_reqrsp_arbiter_if.sv
// Request/response bus between a reqrsp initiator (master) and target (slave).
// The q channel carries requests, the p channel carries read data back.
interface hwpe_ctrl_intf_reqrsp #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    logic            q_valid;
    logic            q_ready;
    logic [AW-1:0]   q_addr;
    logic            q_write;
    logic [DW-1:0]   q_data;
    logic [DW/8-1:0] q_strb;
    logic            p_valid;
    logic            p_ready;
    logic [DW-1:0]   p_data;

    modport master (
        output q_valid, q_addr, q_write, q_data, q_strb, p_ready,
        input  q_ready, p_valid, p_data
    );

    modport slave (
        input  q_valid, q_addr, q_write, q_data, q_strb, p_ready,
        output q_ready, p_valid, p_data
    );

endinterface

// File: rtl/hwpe_ctrl_reqrsp_arbiter_id_fifo.sv
// Small FIFO of initiator indices, one entry per response still owed by the
// target. Occupancy is purely registered so "full" never depends on the
// current cycle's handshakes.
module hwpe_ctrl_reqrsp_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping; a clear discards every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/hwpe_ctrl_reqrsp_arbiter.sv
// Round-robin arbiter sharing one reqrsp target among N_IN initiators.
// Requests pass through combinationally; responses are steered back using
// the order in which requests were accepted.
module hwpe_ctrl_reqrsp_arbiter
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_IN            = 2,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          WRITE_RSP       = 1'b0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    hwpe_ctrl_intf_reqrsp.slave                  in [N_IN],
    hwpe_ctrl_intf_reqrsp.master                 out,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 rsp_err_o
);

    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic            q_valid_arr [N_IN];
    logic            q_write_arr [N_IN];
    logic [AW-1:0]   q_addr_arr  [N_IN];
    logic [DW-1:0]   q_data_arr  [N_IN];
    logic [DW/8-1:0] q_strb_arr  [N_IN];
    logic            p_ready_arr [N_IN];
    logic            q_ready_arr [N_IN];
    logic            p_valid_arr [N_IN];

    reqrsp_arb_state_t state_q, state_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  grant;

    logic             out_q_valid;
    logic             out_p_ready;
    logic             q_hs;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;

    // Flatten the interface array so the rest of the logic can index it with
    // a run-time grant.
    for (genvar g = 0; g < N_IN; g++) begin : gen_in
        assign q_valid_arr[g] = in[g].q_valid;
        assign q_write_arr[g] = in[g].q_write;
        assign q_addr_arr[g]  = in[g].q_addr;
        assign q_data_arr[g]  = in[g].q_data;
        assign q_strb_arr[g]  = in[g].q_strb;
        assign p_ready_arr[g] = in[g].p_ready;
        assign in[g].q_ready  = q_ready_arr[g];
        assign in[g].p_valid  = p_valid_arr[g];
        assign in[g].p_data   = out.p_data;
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
        end
    end

    // Grant: held initiator while locked, otherwise first valid from rr_q up.
    always_comb begin
        int idx;
        logic found;
        grant = rr_q;
        found = 1'b0;
        idx   = 0;
        if (state_q == LOCKED) begin
            grant = lock_idx_q;
        end else begin
            for (int k = 0; k < int'(N_IN); k++) begin
                idx = (int'(rr_q) + k) % int'(N_IN);
                if (!found && q_valid_arr[IDX_W'(idx)]) begin
                    grant = IDX_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Next state: lock on a stalled request, release on its handshake,
    // advance the pointer past whoever just got through.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        if (q_hs) begin
            rr_d = (grant == IDX_W'(N_IN - 1)) ? '0 : grant + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (out_q_valid && !out.q_ready) begin
                    state_d    = LOCKED;
                    lock_idx_d = grant;
                end
            end
            LOCKED: begin
                if (q_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d    = IDLE;
            lock_idx_d = '0;
            rr_d       = '0;
        end
    end

    // Request and response steering; full only looks at registered occupancy
    // so out.q_ready never feeds back into out.q_valid.
    always_comb begin
        for (int i = 0; i < int'(N_IN); i++) begin
            q_ready_arr[i] = 1'b0;
            p_valid_arr[i] = 1'b0;
        end
        out_q_valid        = q_valid_arr[grant] & ~fifo_full;
        q_ready_arr[grant] = out.q_ready & ~fifo_full;
        if (fifo_empty) begin
            out_p_ready = 1'b1;
        end else begin
            out_p_ready            = p_ready_arr[fifo_head];
            p_valid_arr[fifo_head] = out.p_valid;
        end
    end

    assign out.q_valid = out_q_valid;
    assign out.q_addr  = q_addr_arr[grant];
    assign out.q_write = q_write_arr[grant];
    assign out.q_data  = q_data_arr[grant];
    assign out.q_strb  = q_strb_arr[grant];
    assign out.p_ready = out_p_ready;

    assign q_hs          = out_q_valid & out.q_ready;
    assign fifo_push     = q_hs & (~q_write_arr[grant] | WRITE_RSP) & ~clear_i;
    assign fifo_pop      = out.p_valid & out_p_ready & ~fifo_empty & ~clear_i;
    assign rsp_err_o     = out.p_valid & fifo_empty;
    assign outstanding_o = fifo_count;

    hwpe_ctrl_reqrsp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (grant),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: doc/hwpe_ctrl_reqrsp_arbiter.md
# hwpe_ctrl_reqrsp_arbiter

Round-robin arbiter that shares one reqrsp configuration target (e.g. `hwpe_ctrl_reqrsp_target`) among `N_IN` reqrsp initiators. It sits between the cluster-side initiators (cores, DMA, debug) and the HWPE control port. Requests are granted one per cycle with zero added latency. Responses are routed back in request order through an initiator-ID FIFO that bounds the number of outstanding transactions.

## Interface
- `N_IN`, 2: number of initiators, ≥2.
- `AW`, 32: address width.
- `DW`, 64: data width.
- `MAX_OUTSTANDING`, 4: ID FIFO depth, ≥1.
- `WRITE_RSP`, 0: 1 means writes also return a p-channel response; 0 means only reads do.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_i`  in  1  synchronous clear of pointer, lock and FIFO.
- `in`  `hwpe_ctrl_intf_reqrsp.slave` array  [`N_IN`]  initiator ports (`AW`/`DW`).
- `out`  `hwpe_ctrl_intf_reqrsp.master`  1  target port.
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING+1)`  current FIFO occupancy.
- `rsp_err_o`  out  1  one-cycle pulse on a response with empty FIFO.

## Operation
- **Registered state**
  - `rr_q`: priority pointer, index of the highest-priority initiator.
  - `state_q`: one of `IDLE` or `LOCKED`.
  - `lock_idx_q`: initiator held while `LOCKED`.
  - ID FIFO.
- **Grant selection**
  - In `IDLE`, the grant goes to the first `in[i].q_valid` scanning from `rr_q` upward, modulo `N_IN`.
  - In `LOCKED`, the grant is `lock_idx_q`.
- **Request path (combinational)**
  - `out.q_addr/q_write/q_data/q_strb` = `in[grant]`.
  - `out.q_valid` = `in[grant].q_valid & ~full`.
  - `in[grant].q_ready` = `out.q_ready & ~full`. All other `q_ready` are 0.
- **State transitions**
  - `IDLE` → `LOCKED` when `out.q_valid & ~out.q_ready`; `lock_idx_q` ← grant.
  - `LOCKED` → `IDLE` on the q handshake.
  - The lock prevents grant switching while the target has not yet accepted.
- **On a q handshake**
  - `rr_q` ← (grant+1) mod `N_IN`.
  - If `~q_write | WRITE_RSP`, the grant index is pushed into the FIFO.
- **Full FIFO**
  - Full blocks request handshakes even if a pop occurs in the same cycle; the request is accepted the following cycle.
- **Response path (FIFO non-empty)**
  - `in[head].p_data/p_valid` = `out.p_*`; `out.p_ready` = `in[head].p_ready`.
  - Other initiators see `p_valid` = 0.
  - Pop on p handshake.
- **Response path (FIFO empty)**
  - `out.p_ready` = 1 and the response is dropped.
  - `rsp_err_o` pulses if `out.p_valid`.
- **Simultaneous push and pop** (not full): occupancy unchanged.
- **`clear_i`**
  - `rr_q` = 0, `IDLE`, FIFO empty.
  - Takes priority over any handshake in the same cycle.

## Timing
- **Reset/clear values**
  - `rr_q` = 0, `state_q` = `IDLE`, `lock_idx_q` = 0.
  - FIFO empty, `outstanding_o` = 0, `rsp_err_o` = 0.
  - All `in[].q_ready` and `in[].p_valid` = 0 until driven by valid traffic.
- **Latency**
  - Request and response paths: 0 cycles, combinational passthrough.
  - Arbitration state updates at the clock edge after a handshake.
- **Throughput**: one request per cycle. Back-to-back requests from different initiators are granted in consecutive cycles.
- **Reset mid-transaction**: all state is discarded; in-flight responses after reset assert `rsp_err_o`.
- **Combinational loops**: no combinational path from `out.q_ready` to `out.q_valid`. `full` is derived from registered occupancy only.

## Structure
- **`hwpe_ctrl_package`** gains:
  - `reqrsp_arb_state_t` enum (`IDLE`, `LOCKED`).
  - Reqrsp register offset constants `TRIGGER`=0 … `PULL`=5, shared with the benches.
- **Sub-module `hwpe_ctrl_reqrsp_id_fifo`**
  - Parameters: `DEPTH`, `WIDTH=$clog2(N_IN)`.
  - Ports: `push`/`pop`/`din`/`dout`, `full`/`empty`, `count`, `clear`.
  - Same reset as the parent.
- **Top**: arbitration logic only.

## Test plan
- **Single write passthrough**: `in[0]` writes addr 0x20 (PUSH), data 0x12345678_9ABCDEF0. → `out` shows identical fields the same cycle; `outstanding_o` stays 0 (`WRITE_RSP`=0).
- **Simultaneous reads**: `rr_q`=0; `in[0]` reads 0x08 (STATUS) and `in[1]` reads 0x10 (JOBID) in the same cycle. → `in[0]` is granted in cycle 0 and `in[1]` in cycle 1. The target returns 0 then 1, and these arrive at `in[0]` then `in[1]` respectively.
- **Lock**: `in[1]` valid with target `q_ready` low for 3 cycles, and `in[0]` raises valid in cycle 1. → `out.q_addr` stays at `in[1]`'s address for all 3 cycles, and `in[0]` is granted after the handshake.
- **FIFO full**: 4 reads issued with initiator `p_ready` low. → `outstanding_o`=4 and the 5th read stalls (`q_ready`=0). One p handshake → 5th read accepted on the next cycle; `outstanding_o` returns to 4.
- **Response backpressure**: `in[1].p_ready` low for 2 cycles. → `out.p_ready` low for 2 cycles; `in[0].p_valid` stays 0 throughout.
- **Spurious response and reset**: `out.p_valid` asserted with the FIFO empty. → `rsp_err_o` pulses for 1 cycle and `out.p_ready`=1. Assert `rst_ni` low with 2 outstanding. → `outstanding_o`=0 and `state_q`=`IDLE` immediately.
